// File: rtl/ff_excitation_driver.sv
// Stimulus/checker end of a flip-flop excitation link: drives S/R or J/K so the
// downstream flip-flop's q follows a requested bit sequence, and counts q mismatches.
module ff_excitation_driver #(
  parameter int W             = 8,
  parameter int PREFER_TOGGLE = 0,
  parameter int CW            = $clog2(W+2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [W-1:0]           pattern,
  input  logic [$clog2(W+1)-1:0] len,
  input  logic                   q_fb,
  output logic                   s_j,
  output logic                   r_k,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          err_cnt,
  output logic                   mismatch
);

  localparam int LW = $clog2(W+1);

  // Handshake: start is a one-cycle request, accepted only in IDLE; busy covers
  // accept edge up to the done pulse, and requests seen while busy are dropped.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic          jk_q;
  logic [W-1:0]  sh;
  logic [LW-1:0] len_q;
  logic [LW-1:0] rem;
  logic          prev;
  logic          cur;

  // Excitation needed for a from->to transition; derived from expected state only.
  function automatic logic [1:0] exc(input logic jk, input logic from_b, input logic to_b);
    if (from_b == to_b)                exc = 2'b00;
    else if (jk && PREFER_TOGGLE != 0) exc = 2'b11;
    else if (to_b)                     exc = 2'b10;
    else                               exc = 2'b01;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_j      <= 1'b0;
      r_k      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
      mismatch <= 1'b0;
      jk_q     <= 1'b0;
      sh       <= '0;
      len_q    <= '0;
      rem      <= '0;
      prev     <= 1'b0;
      cur      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= CLEAR;
            jk_q     <= mode;
            sh       <= pattern;
            len_q    <= (len > LW'(W)) ? LW'(W) : len;
            err_cnt  <= '0;
            mismatch <= 1'b0;
            busy     <= 1'b1;
            s_j      <= 1'b0;
            r_k      <= 1'b1;
          end
        end
        CLEAR: begin
          prev <= 1'b0;
          if (len_q != '0) begin
            state      <= RUN;
            rem        <= len_q - LW'(1);
            cur        <= sh[0];
            sh         <= sh >> 1;
            {s_j, r_k} <= exc(jk_q, 1'b0, sh[0]);
          end else begin
            state      <= DRAIN;
            {s_j, r_k} <= 2'b00;
          end
        end
        RUN: begin
          if (q_fb != prev) begin
            mismatch <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
          end
          prev <= cur;
          if (rem == '0) begin
            state      <= DRAIN;
            {s_j, r_k} <= 2'b00;
          end else begin
            rem        <= rem - LW'(1);
            cur        <= sh[0];
            sh         <= sh >> 1;
            {s_j, r_k} <= exc(jk_q, cur, sh[0]);
          end
        end
        DRAIN: begin
          if (q_fb != prev) begin
            mismatch <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
          end
          state      <= DONE;
          done       <= 1'b1;
          busy       <= 1'b0;
          {s_j, r_k} <= 2'b00;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          {s_j, r_k} <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Loopback bench: a behavioural SR/JK flip-flop closes the loop, a scoreboard
// holds expected per-cycle outputs and per-sequence results, a monitor compares.
module tb_ff_excitation_driver;

  localparam int W  = 8;
  localparam int LW = $clog2(W+1);
  localparam int CW = $clog2(W+2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  pattern = '0;
  logic [LW-1:0] len = '0;
  logic          q_fb;
  logic          s_j, r_k, busy, done, mismatch;
  logic [CW-1:0] err_cnt;

  logic q_ff = 1'b0;
  logic ff_jk = 1'b0;
  logic fault = 1'b0;

  logic [3:0]    exc_q[$];   // {s_j, r_k, busy, done} per cycle after accept
  logic [CW:0]   res_q[$];   // {mismatch, err_cnt} at the done pulse

  int errors = 0;
  int checks = 0;

  ff_excitation_driver #(.W(W), .PREFER_TOGGLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pattern(pattern),
    .len(len), .q_fb(q_fb), .s_j(s_j), .r_k(r_k), .busy(busy), .done(done),
    .err_cnt(err_cnt), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Downstream flip-flop model; fault forces the returned q low.
  always @(posedge clk) begin
    case ({s_j, r_k})
      2'b10:   q_ff <= 1'b1;
      2'b01:   q_ff <= 1'b0;
      2'b11:   if (ff_jk) q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end
  assign q_fb = fault ? 1'b0 : q_ff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle compares the registered outputs to the expected stream.
  always @(posedge clk) begin
    logic [3:0]  e;
    logic [CW:0] r;
    #1;
    if (exc_q.size() > 0) begin
      e = exc_q.pop_front();
      check("outs", {28'd0, s_j, r_k, busy, done}, {28'd0, e});
    end else begin
      check("idle_outs", {28'd0, s_j, r_k, busy, done}, 32'd0);
    end
    if (done === 1'b1) begin
      if (res_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        r = res_q.pop_front();
        check("err_cnt", 32'(err_cnt), 32'(r[CW-1:0]));
        check("mismatch", 32'(mismatch), 32'(r[CW]));
      end
    end
  end

  function automatic logic [1:0] tb_exc(input logic jk, input logic a, input logic b);
    if (a == b)     return 2'b00;
    else if (jk)    return 2'b11;
    else if (b)     return 2'b10;
    else            return 2'b01;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Push the expected stream for one sequence, then pulse start (accepted next posedge).
  task automatic launch(input logic m, input logic [7:0] pat, input int l, input int exp_err);
    logic [7:0] p;
    int lc;
    logic pv;
    p  = pat;
    lc = (l > W) ? W : l;
    exc_q.push_back(4'b0110);
    for (int i = 0; i < lc; i++) begin
      pv = (i == 0) ? 1'b0 : p[i-1];
      exc_q.push_back({tb_exc(m, pv, p[i]), 2'b10});
    end
    exc_q.push_back(4'b0010);
    exc_q.push_back(4'b0001);
    exc_q.push_back(4'b0000);
    res_q.push_back({(exp_err != 0), CW'(exp_err)});
    ff_jk   = m;
    mode    = m;
    pattern = pat;
    len     = LW'(l);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  initial begin
    wait_n(3);
    rst = 1'b0;
    wait_n(2);

    // SR loopback, full length
    launch(1'b0, 8'b0110_1001, 8, 0);
    wait_n(12);
    // JK loopback with toggle excitation
    launch(1'b1, 8'b0101_0101, 8, 0);
    wait_n(12);
    // Fault injection: q stuck low on an all-ones run
    fault = 1'b1;
    launch(1'b0, 8'h0F, 4, 4);
    wait_n(8);
    fault = 1'b0;
    wait_n(1);
    // len = 0 and clamped len = W+1
    launch(1'b0, 8'hA5, 0, 0);
    wait_n(4);
    launch(1'b0, 8'hA5, 9, 0);
    wait_n(12);

    // start pulses during RUN and DONE are dropped; start right after DONE accepted
    launch(1'b0, 8'h3C, 5, 0);
    wait_n(2);
    mode = 1'b1; pattern = 8'hFF; len = LW'(2); start = 1'b1;
    wait_n(1);
    start = 1'b0;
    wait_n(4);
    start = 1'b1;
    wait_n(1);
    launch(1'b1, 8'b0000_0110, 4, 0);
    wait_n(8);

    // Reset during RUN cycle 3 with errors already counted
    fault = 1'b1;
    launch(1'b0, 8'hFF, 8, 8);
    wait_n(4);
    check("err_before_rst", 32'(err_cnt), 32'd2);
    check("mm_before_rst", 32'(mismatch), 32'd1);
    rst = 1'b1;
    exc_q.delete();
    res_q.delete();
    wait_n(1);
    rst = 1'b0;
    fault = 1'b0;
    check("err_after_rst", 32'(err_cnt), 32'd0);
    check("mm_after_rst", 32'(mismatch), 32'd0);
    wait_n(2);
    launch(1'b0, 8'b1100_1010, 8, 0);
    wait_n(14);

    check("exc_q_drained", 32'(exc_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
